// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - Raster-stream 3x3 window sequencer for an external Sobel operator
// Two line buffers build each window; results land in a 2-entry output FIFO with backpressure.
module sobel_window_ctrl #(
  parameter int IMG_W      = 720,
  parameter int IMG_H      = 540,
  parameter int DWIDTH_OUT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DWIDTH_OUT-1:0]   in_data,
  output logic [9*DWIDTH_OUT-1:0] op_in,
  input  logic [DWIDTH_OUT-1:0]   op_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DWIDTH_OUT-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int DW = DWIDTH_OUT;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [DW-1:0]   lb0 [IMG_W];
  logic [DW-1:0]   lb1 [IMG_W];
  logic [DW-1:0]   win_a [3];
  logic [DW-1:0]   win_b [3];
  logic [DW-1:0]   new_col [3];
  logic [9*DW-1:0] window;

  logic          pending, pending_last;
  logic [1:0]    count;
  logic [DW-1:0] fd0, fd1;
  logic          fl0, fl1;

  logic accept, issue, last_px, push, pop;

  assign accept  = in_valid && in_ready;
  assign issue   = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign last_px = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign push    = pending;
  assign pop     = out_valid && out_ready;

  // pending counts as an occupied slot so a result already in flight always has room
  assign in_ready  = (state != DRAIN) && ((count + {1'b0, pending}) < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = fd0;
  assign out_last  = fl0 && out_valid;
  assign busy      = !((state == FILL) && (row == '0) && (col == '0));

  always_comb begin
    new_col[0] = lb1[col];
    new_col[1] = lb0[col];
    new_col[2] = in_data;
    window     = '0;
    for (int r = 0; r < 3; r++) begin
      window[(r*3+0)*DW +: DW] = win_a[r];
      window[(r*3+1)*DW +: DW] = win_b[r];
      window[(r*3+2)*DW +: DW] = new_col[r];
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FILL;
      col          <= '0;
      row          <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      count        <= 2'd0;
      fd0          <= '0;
      fd1          <= '0;
      fl0          <= 1'b0;
      fl1          <= 1'b0;
      op_in        <= '0;
      for (int r = 0; r < 3; r++) begin
        win_a[r] <= '0;
        win_b[r] <= '0;
      end
    end else begin
      if (accept) begin
        win_a <= win_b;
        win_b <= new_col;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      pending      <= issue;
      pending_last <= last_px;
      if (issue) op_in <= window;

      // head lives in slot 0; an empty FIFO keeps the last popped value visible
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            fd0 <= op_out;
            fl0 <= pending_last;
          end else begin
            fd1 <= op_out;
            fl1 <= pending_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            fd0 <= fd1;
            fl0 <= fl1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fd0 <= op_out;
            fl0 <= pending_last;
          end else begin
            fd0 <= fd1;
            fl0 <= fl1;
            fd1 <= op_out;
            fl1 <= pending_last;
          end
        end
        default: ;
      endcase

      case (state)
        FILL, RUN: begin
          if (accept) state <= last_px ? DRAIN : (issue ? RUN : FILL);
        end
        DRAIN: begin
          if ((count == 2'd0) && !pending) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - Self-checking bench for sobel_window_ctrl on a 5x4 image
// A frame-level model computes expected Sobel results directly from the generated image.
module tb_sobel_window_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [71:0]   op_in;
  logic [DW-1:0] op_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DWIDTH_OUT(DW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op_in(op_in), .op_out(op_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] sobel_f(input logic [71:0] w);
    int p [9];
    int gx, gy, m;
    for (int a = 0; a < 9; a++) p[a] = int'(w[a*8 +: 8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) / 2;
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  // stand-in for sobel_op: result presented one cycle after the window is issued
  assign op_out = sobel_f(op_in);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] pix_q [$];
  logic [8:0] exp_q [$];
  int valid_pct, ready_pct, accepted, got, lasts, b2b, first_data;

  task automatic gen_frame(input int pattern);
    logic [7:0]  img [H][W];
    logic [71:0] w;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (pattern)
          0:       img[r][c] = 8'd50;
          1:       img[r][c] = (c < 2) ? 8'd0 : 8'd100;
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
        pix_q.push_back(img[r][c]);
      end
    for (int r = 1; r <= H-2; r++)
      for (int c = 1; c <= W-2; c++) begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            w[(rr*3+cc)*8 +: 8] = img[r-1+rr][c-1+cc];
        exp_q.push_back({(r == H-2) && (c == W-2), sobel_f(w)});
      end
  endtask

  task automatic driver();
    int guard = 0;
    while (pix_q.size() > 0 && guard < 4000) begin
      @(negedge clock);
      if ($urandom_range(1, 100) <= valid_pct) begin
        in_valid = 1'b1;
        in_data  = pix_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        accepted++;
      end
      guard++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("driver_done", pix_q.size(), 0);
  endtask

  task automatic monitor(input int n, input int hold);
    int guard = 0;
    bit prev_pop = 0;
    logic [8:0] e;
    got = 0; lasts = 0; b2b = 0; first_data = -1;
    while (got < n && guard < 4000) begin
      @(negedge clock);
      if (hold > 0) begin
        hold--;
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        check("out_data", out_data, e[7:0]);
        check("out_last", out_last, e[8]);
        if (first_data < 0) first_data = int'(out_data);
        if (out_last) lasts++;
        if (prev_pop) b2b++;
        prev_pop = 1;
        got++;
      end else begin
        prev_pop = 0;
      end
      guard++;
    end
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("busy_after_drain", busy, 0);
    check("no_extra_result", out_valid, 0);
    check("in_ready_idle", in_ready, 1);
  endtask

  typedef struct {
    logic [95:0] name;
    int pattern, frames, vpct, rpct, exp_results, exp_lasts, exp_first;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{"const50",   0, 1, 100, 100,  6, 1,   0};
    tbl[1] = '{"step",      1, 1, 100, 100,  6, 1, 200};
    tbl[2] = '{"rand_gaps", 2, 1,  60,  70,  6, 1,  -1};
    tbl[3] = '{"slow_sink", 2, 1, 100,  30,  6, 1,  -1};
    tbl[4] = '{"b2b_rand",  2, 2,  70,  80, 12, 2,  -1};

    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_op_in", op_in, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pix_q.delete();
      exp_q.delete();
      for (int f = 0; f < tbl[i].frames; f++) gen_frame(tbl[i].pattern);
      valid_pct = tbl[i].vpct;
      ready_pct = tbl[i].rpct;
      fork
        driver();
        monitor(tbl[i].exp_results, 0);
      join
      check({"count_", tbl[i].name}, got, tbl[i].exp_results);
      check({"lasts_", tbl[i].name}, lasts, tbl[i].exp_lasts);
      if (tbl[i].exp_first >= 0) check({"first_", tbl[i].name}, first_data, tbl[i].exp_first);
      if (tbl[i].rpct == 100) check({"push_pop_", tbl[i].name}, b2b > 0, 1);
      wait_idle();
    end

    // sink stalled: 14 pixels fit before the FIFO plus in-flight result block input
    pix_q.delete();
    exp_q.delete();
    gen_frame(2);
    valid_pct = 100;
    ready_pct = 100;
    accepted  = 0;
    fork
      driver();
      monitor(6, 30);
      begin
        repeat (28) @(negedge clock);
        #1;
        check("stall_accepted", accepted, 14);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
      end
    join
    check("stall_count", got, 6);
    check("stall_lasts", lasts, 1);
    wait_idle();

    // reset in the middle of a frame, then a clean constant frame
    pix_q.delete();
    exp_q.delete();
    for (int k = 0; k < 7; k++) pix_q.push_back(8'($urandom_range(0, 255)));
    valid_pct = 100;
    driver();
    check("midframe_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("post_reset_busy", busy, 0);
    check("post_reset_out_valid", out_valid, 0);
    gen_frame(0);
    ready_pct = 100;
    fork
      driver();
      monitor(6, 0);
    join
    check("reset_frame_count", got, 6);
    check("reset_frame_lasts", lasts, 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
